// File: rtl/gig_eth_mac_tx_v2_if.sv
// Client-side byte stream between the TX client and the gigabit MAC transmitter.
interface gig_eth_mac_tx_v2_if;
    logic [7:0] mac_tx_data;
    logic       mac_tx_dvld;
    logic       mac_tx_underrun;
    logic       mac_tx_ack;

    modport master (output mac_tx_data, mac_tx_dvld, mac_tx_underrun, input mac_tx_ack);
    modport slave  (input mac_tx_data, mac_tx_dvld, mac_tx_underrun, output mac_tx_ack);
endinterface

// File: rtl/gig_eth_mac_tx_v2.sv
// Gigabit Ethernet TX MAC: preamble/SFD, optional padding, CRC-32 FCS, IFG
// enforcement, size limits, underrun handling and frame/error statistics.
module gig_eth_mac_tx_v2 #(
    parameter int MAX_FRAME_SIZE_STANDARD = 1522,
    parameter int MAX_FRAME_SIZE_JUMBO    = 9022,
    parameter int MIN_FRAME_SIZE          = 64,
    parameter int IFG_MIN                 = 12,
    parameter int CNT_WIDTH               = 32
) (
    input  logic                 tx_clk,
    input  logic                 reset_n,
    input  logic                 conf_tx_en,
    input  logic                 conf_tx_no_gen_crc,
    input  logic                 conf_tx_jumbo_en,
    input  logic                 conf_tx_pad_en,
    input  logic [7:0]           conf_tx_ifg,
    gig_eth_mac_tx_v2_if.slave   client,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_txen,
    output logic                 gmii_txer,
    output logic [CNT_WIDTH-1:0] stat_tx_frames,
    output logic [CNT_WIDTH-1:0] stat_tx_errors,
    output logic                 tx_busy
);

    localparam logic [13:0] LIM_STD    = 14'(MAX_FRAME_SIZE_STANDARD);
    localparam logic [13:0] LIM_JUMBO  = 14'(MAX_FRAME_SIZE_JUMBO);
    localparam logic [13:0] PAD_TARGET = 14'(MIN_FRAME_SIZE - 4);
    localparam logic [7:0]  IFG_FLOOR  = 8'(IFG_MIN);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ERROR, DROP, IFG
    } state_t;

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [13:0] byte_cnt;
    logic [1:0]  fcs_idx;
    logic [7:0]  ifg_cnt;
    logic [31:0] crc;
    logic        gen_crc_q;
    logic        pad_q;
    logic        jumbo_q;

    logic [13:0] lim;
    logic [7:0]  ifg_eff;
    logic [7:0]  ifg_load;
    logic [31:0] fcs_inv;
    logic [1:0]  fcs_nxt;
    logic        in_payload;
    logic        abort;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        lim        = (jumbo_q ? LIM_JUMBO : LIM_STD) - (gen_crc_q ? 14'd4 : 14'd0);
        ifg_eff    = (conf_tx_ifg < IFG_FLOOR) ? IFG_FLOOR : conf_tx_ifg;
        // IFG state lasts ifg_eff-1 cycles; the IDLE cycle supplies the last gap byte time
        ifg_load   = ifg_eff - 8'd2;
        fcs_inv    = ~crc;
        fcs_nxt    = fcs_idx + 2'd1;
        in_payload = (state == SFD) || (state == DATA);
        abort      = (client.mac_tx_underrun &&
                      ((state == DATA) || (state == PAD) || (state == FCS))) ||
                     (in_payload && client.mac_tx_dvld && (byte_cnt == lim));
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            pre_cnt           <= '0;
            byte_cnt          <= '0;
            fcs_idx           <= '0;
            ifg_cnt           <= '0;
            crc               <= '1;
            gen_crc_q         <= 1'b0;
            pad_q             <= 1'b0;
            jumbo_q           <= 1'b0;
            gmii_txd          <= '0;
            gmii_txen         <= 1'b0;
            gmii_txer         <= 1'b0;
            client.mac_tx_ack <= 1'b0;
            stat_tx_frames    <= '0;
            stat_tx_errors    <= '0;
            tx_busy           <= 1'b0;
        end else begin
            client.mac_tx_ack <= 1'b0;
            gmii_txer         <= 1'b0;
            if (abort) begin
                state          <= ERROR;
                gmii_txen      <= 1'b1;
                gmii_txer      <= 1'b1;
                gmii_txd       <= 8'h00;
                stat_tx_errors <= stat_tx_errors + 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (client.mac_tx_dvld && conf_tx_en) begin
                            state     <= PREAMBLE;
                            gmii_txd  <= 8'h55;
                            gmii_txen <= 1'b1;
                            tx_busy   <= 1'b1;
                            pre_cnt   <= '0;
                            byte_cnt  <= '0;
                            crc       <= '1;
                            gen_crc_q <= ~conf_tx_no_gen_crc;
                            pad_q     <= conf_tx_pad_en;
                            jumbo_q   <= conf_tx_jumbo_en;
                        end
                    end
                    PREAMBLE: begin
                        if (pre_cnt == 3'd6) begin
                            state             <= SFD;
                            gmii_txd          <= 8'hD5;
                            client.mac_tx_ack <= 1'b1;
                        end else begin
                            pre_cnt <= pre_cnt + 3'd1;
                        end
                    end
                    SFD, DATA: begin
                        if (client.mac_tx_dvld) begin
                            state    <= DATA;
                            gmii_txd <= client.mac_tx_data;
                            crc      <= crc_byte(crc, client.mac_tx_data);
                            byte_cnt <= byte_cnt + 14'd1;
                        end else if (gen_crc_q && pad_q && (byte_cnt < PAD_TARGET)) begin
                            state    <= PAD;
                            gmii_txd <= 8'h00;
                            crc      <= crc_byte(crc, 8'h00);
                            byte_cnt <= byte_cnt + 14'd1;
                        end else if (gen_crc_q) begin
                            state    <= FCS;
                            gmii_txd <= fcs_inv[7:0];
                            fcs_idx  <= '0;
                        end else begin
                            state          <= IFG;
                            gmii_txen      <= 1'b0;
                            gmii_txd       <= 8'h00;
                            ifg_cnt        <= ifg_load;
                            stat_tx_frames <= stat_tx_frames + 1'b1;
                        end
                    end
                    PAD: begin
                        if (byte_cnt == PAD_TARGET) begin
                            state    <= FCS;
                            gmii_txd <= fcs_inv[7:0];
                            fcs_idx  <= '0;
                        end else begin
                            gmii_txd <= 8'h00;
                            crc      <= crc_byte(crc, 8'h00);
                            byte_cnt <= byte_cnt + 14'd1;
                        end
                    end
                    FCS: begin
                        if (fcs_idx == 2'd3) begin
                            state     <= IFG;
                            gmii_txen <= 1'b0;
                            gmii_txd  <= 8'h00;
                            ifg_cnt   <= ifg_load;
                        end else begin
                            fcs_idx  <= fcs_nxt;
                            gmii_txd <= fcs_inv[{fcs_nxt, 3'b000} +: 8];
                            if (fcs_idx == 2'd2)
                                stat_tx_frames <= stat_tx_frames + 1'b1;
                        end
                    end
                    ERROR: begin
                        state     <= DROP;
                        gmii_txen <= 1'b0;
                        gmii_txd  <= 8'h00;
                    end
                    DROP: begin
                        if (!client.mac_tx_dvld) begin
                            state   <= IFG;
                            ifg_cnt <= ifg_load;
                        end
                    end
                    IFG: begin
                        if (ifg_cnt == 8'd0) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end else begin
                            ifg_cnt <= ifg_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        gmii_txen <= 1'b0;
                        tx_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
